// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK register bank.
package jk_pkg;
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_UP = 2'b01;
    localparam logic [1:0] MODE_DN = 2'b10;
    localparam logic [1:0] MODE_LD = 2'b11;
endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset and a clock enable.
module jk_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_BIT;
        end else if (en) begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank: per-bit JK, up/down counting via toggle chains, parallel load.
// Optional capture register enabled by defining JKBANK_SNAPSHOT_EN.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             wrap
`ifdef JKBANK_SNAPSHOT_EN
    ,
    input  logic             snap,
    output logic [WIDTH-1:0] snap_q
`endif
);
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] up_chain;
    logic [WIDTH-1:0] dn_chain;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             wrap_q;
    logic             wrap_d;

    // Bit i toggles when all lower bits are ones (up) or all zeros (down).
    assign up_chain[0] = 1'b1;
    assign dn_chain[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign up_chain[gi] = up_chain[gi-1] & bank_q[gi-1];
            assign dn_chain[gi] = dn_chain[gi-1] & ~bank_q[gi-1];
        end
    endgenerate

    always_comb begin
        cell_j = '0;
        cell_k = '0;
        case (mode)
            MODE_JK: begin
                cell_j = j;
                cell_k = k;
            end
            MODE_UP: begin
                cell_j = up_chain;
                cell_k = up_chain;
            end
            MODE_DN: begin
                cell_j = dn_chain;
                cell_k = dn_chain;
            end
            default: begin
                cell_j = j;
                cell_k = ~j;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell #(
                .RST_BIT(RST_VAL[gi])
            ) u_cell (
                .clk(clk),
                .rst(rst),
                .en (en),
                .j  (cell_j[gi]),
                .k  (cell_k[gi]),
                .q  (bank_q[gi])
            );
        end
    endgenerate

    // Wrap fires when every bit of the chain toggles at once.
    always_comb begin
        wrap_d = 1'b0;
        if (en) begin
            if (mode == MODE_UP) begin
                wrap_d = up_chain[WIDTH-1] & bank_q[WIDTH-1];
            end else if (mode == MODE_DN) begin
                wrap_d = dn_chain[WIDTH-1] & ~bank_q[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q    = bank_q;
    assign wrap = wrap_q;

`ifdef JKBANK_SNAPSHOT_EN
    logic [WIDTH-1:0] snap_q_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q_q <= RST_VAL;
        end else if (snap) begin
            snap_q_q <= bank_q;
        end
    end

    assign snap_q = snap_q_q;
`endif
endmodule
